// File: rtl/vga_layer_mixer.sv
// vga_layer_mixer: two-stage pixel compositor for the VGA path.
// Layers are merged by fixed priority (layer 0 on top, last layer is the
// background) with colour-key transparency. A frame-synchronised overlay
// can cover the whole screen for a number of frames. Sprite overlaps are
// flagged per pixel and summarised per frame.
//
// Overlay FSM states
//   state    | meaning
//   ST_IDLE  | no overlay pending or shown
//   ST_ARMED | overlay requested, waiting for the first pixel of a frame
//   ST_SHOW  | overlay visible, frame_cnt counts completed frame starts
module vga_layer_mixer #(
    parameter int NUM_LAYERS     = 4,
    parameter int COLOR_W        = 12,
    parameter int KEY_WHITE      = 1,
    parameter int OVERLAY_FRAMES = 120
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [9:0]                    pix_row,
    input  logic [9:0]                    pix_col,
    input  logic                          video_on,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_in,
    input  logic [NUM_LAYERS-1:0]         layer_en,
    input  logic [COLOR_W-1:0]            overlay_in,
    input  logic                          overlay_trigger,
    input  logic                          overlay_clear,
    output logic [COLOR_W-1:0]            vga_out,
    output logic                          overlay_active,
    output logic                          collision_pulse,
    output logic                          collision_status
);

    // Sprite layers are 0..NUM_LAYERS-2; the last layer is the background.
    localparam int NUM_SPR = NUM_LAYERS - 1;
    localparam int BG_IDX  = NUM_LAYERS - 1;
    localparam int PC_W    = $clog2(NUM_LAYERS) + 1;
    localparam int CNT_W   = $clog2((OVERLAY_FRAMES > 2) ? OVERLAY_FRAMES : 2);
    localparam bit HAS_TIMEOUT = (OVERLAY_FRAMES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = HAS_TIMEOUT ? CNT_W'(OVERLAY_FRAMES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    // A colour is transparent when it is all-zeros, or all-ones if white keying is on.
    function automatic logic is_opaque(input logic [COLOR_W-1:0] c);
        logic res;
        res = (c != '0);
        if (KEY_WHITE != 0 && c == '1) begin
            res = 1'b0;
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Raw-input decode
    // ------------------------------------------------------------------
    logic                 frame_start;
    logic [NUM_SPR-1:0]   opaque_raw;
    logic                 ovl_opaque_raw;
    logic [PC_W-1:0]      spr_count;
    logic                 coll_raw;

    // Per-pixel decode of frame start, sprite opacity and overlap count.
    always_comb begin
        frame_start    = (pix_row == 10'd0) && (pix_col == 10'd0);
        ovl_opaque_raw = is_opaque(overlay_in);
        opaque_raw     = '0;
        spr_count      = '0;
        for (int i = 0; i < NUM_SPR; i++) begin
            opaque_raw[i] = layer_en[i] & is_opaque(layer_in[i*COLOR_W +: COLOR_W]);
            spr_count     = spr_count + PC_W'(opaque_raw[i]);
        end
        coll_raw = video_on && (spr_count >= PC_W'(2));
    end

    // ------------------------------------------------------------------
    // Overlay FSM
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             last_frame;
    logic             show_s1_d;

    // FSM state and frame counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Next-state logic; a clear wins over anything else, including a trigger.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (overlay_trigger) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (frame_start) begin
                    state_d     = ST_SHOW;
                    frame_cnt_d = '0;
                end
            end
            ST_SHOW: begin
                if (frame_start) begin
                    if (last_frame) begin
                        state_d = ST_IDLE;
                    end else if (frame_cnt_q != CNT_MAX) begin
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (overlay_clear) begin
            state_d = ST_IDLE;
        end
    end

    // FSM outputs: overlay flag and whether the current raw pixel is overlaid.
    // The frame start that ends the overlay is already a plain pixel, while the
    // frame start that leaves ARMED is already overlaid.
    always_comb begin
        last_frame     = HAS_TIMEOUT && frame_start && (frame_cnt_q == CNT_LAST);
        overlay_active = (state_q == ST_SHOW);
        show_s1_d      = ((state_q == ST_SHOW) && !last_frame) ||
                         ((state_q == ST_ARMED) && frame_start);
    end

    // ------------------------------------------------------------------
    // Stage 1: register raw pixel data
    // ------------------------------------------------------------------
    logic [NUM_LAYERS*COLOR_W-1:0] layer_s1_q, layer_s1_d;
    logic [NUM_SPR-1:0]            opaque_s1_q, opaque_s1_d;
    logic                          bg_en_s1_q, bg_en_s1_d;
    logic [COLOR_W-1:0]            ovl_s1_q, ovl_s1_d;
    logic                          ovl_opaque_s1_q, ovl_opaque_s1_d;
    logic                          video_s1_q, video_s1_d;
    logic                          frame_start_s1_q, frame_start_s1_d;
    logic                          show_s1_q;
    logic                          coll_s1_q, coll_s1_d;

    // Stage-1 next values are the decoded raw inputs.
    always_comb begin
        layer_s1_d       = layer_in;
        opaque_s1_d      = opaque_raw;
        bg_en_s1_d       = layer_en[BG_IDX];
        ovl_s1_d         = overlay_in;
        ovl_opaque_s1_d  = ovl_opaque_raw;
        video_s1_d       = video_on;
        frame_start_s1_d = frame_start;
        coll_s1_d        = coll_raw;
    end

    // Stage-1 pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            layer_s1_q       <= '0;
            opaque_s1_q      <= '0;
            bg_en_s1_q       <= 1'b0;
            ovl_s1_q         <= '0;
            ovl_opaque_s1_q  <= 1'b0;
            video_s1_q       <= 1'b0;
            frame_start_s1_q <= 1'b0;
            show_s1_q        <= 1'b0;
            coll_s1_q        <= 1'b0;
        end else begin
            layer_s1_q       <= layer_s1_d;
            opaque_s1_q      <= opaque_s1_d;
            bg_en_s1_q       <= bg_en_s1_d;
            ovl_s1_q         <= ovl_s1_d;
            ovl_opaque_s1_q  <= ovl_opaque_s1_d;
            video_s1_q       <= video_s1_d;
            frame_start_s1_q <= frame_start_s1_d;
            show_s1_q        <= show_s1_d;
            coll_s1_q        <= coll_s1_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: priority mux and collision tracking
    // ------------------------------------------------------------------
    logic [COLOR_W-1:0] vga_out_q, vga_out_d;
    logic               coll_pulse_q, coll_pulse_d;
    logic               coll_status_q, coll_status_d;
    logic               sticky_q, sticky_d;
    logic               found;

    // Overlay first, then lowest-index opaque sprite, then unkeyed background.
    always_comb begin
        vga_out_d = '0;
        found     = 1'b0;
        if (video_s1_q) begin
            if (show_s1_q && ovl_opaque_s1_q) begin
                vga_out_d = ovl_s1_q;
                found     = 1'b1;
            end
            for (int i = 0; i < NUM_SPR; i++) begin
                if (!found && opaque_s1_q[i]) begin
                    vga_out_d = layer_s1_q[i*COLOR_W +: COLOR_W];
                    found     = 1'b1;
                end
            end
            if (!found && bg_en_s1_q) begin
                vga_out_d = layer_s1_q[BG_IDX*COLOR_W +: COLOR_W];
            end
        end
    end

    // Sticky collision flag restarts at each frame start and hands its value to the status.
    always_comb begin
        coll_pulse_d = coll_s1_q;
        if (frame_start_s1_q) begin
            coll_status_d = sticky_q;
            sticky_d      = coll_s1_q;
        end else begin
            coll_status_d = coll_status_q;
            sticky_d      = sticky_q | coll_s1_q;
        end
    end

    // Stage-2 output and collision registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_out_q     <= '0;
            coll_pulse_q  <= 1'b0;
            coll_status_q <= 1'b0;
            sticky_q      <= 1'b0;
        end else begin
            vga_out_q     <= vga_out_d;
            coll_pulse_q  <= coll_pulse_d;
            coll_status_q <= coll_status_d;
            sticky_q      <= sticky_d;
        end
    end

    assign vga_out          = vga_out_q;
    assign collision_pulse  = coll_pulse_q;
    assign collision_status = coll_status_q;

endmodule
